// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between instruction fetch and data access.
// Data has priority until fetch has been starved STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                i_wait,
  output logic                d_wait,
  output logic                sram_cs_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  output logic [DATA_W/8-1:0] sram_wmask_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic [15:0]         i_wait_cnt,
  output logic [15:0]         d_wait_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {PRI_D, PRI_I} pri_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DATA} owner_e;

  pri_e        state_q, state_d;
  owner_e      resp_owner_q, resp_owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0] i_wait_cnt_q, i_wait_cnt_d;
  logic [15:0] d_wait_cnt_q, d_wait_cnt_d;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req && d_req) begin
      if (state_q == PRI_I) i_gnt = 1'b1;
      else                  d_gnt = 1'b1;
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end
  end

  always_comb begin
    sram_cs_o    = i_gnt | d_gnt;
    sram_we_o    = d_gnt & d_we;
    sram_addr_o  = i_gnt ? i_addr : d_addr;
    sram_wdata_o = d_wdata;
    sram_wmask_o = d_gnt ? d_wmask : '0;
  end

  assign i_wait = i_req & ~i_gnt;
  assign d_wait = d_req & ~d_gnt;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (i_gnt || !i_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Switching on the updated count lets the limit-th data grant hand over the next slot.
    state_d = state_q;
    case (state_q)
      PRI_D:   if (starve_cnt_d >= LIMIT) state_d = PRI_I;
      PRI_I:   if (i_gnt) state_d = PRI_D;
      default: state_d = PRI_D;
    endcase

    resp_owner_d = OWN_NONE;
    if (i_gnt)              resp_owner_d = OWN_IFETCH;
    else if (d_gnt && !d_we) resp_owner_d = OWN_DATA;

    i_wait_cnt_d = i_wait_cnt_q;
    if (i_wait && i_wait_cnt_q != 16'hFFFF) i_wait_cnt_d = i_wait_cnt_q + 16'd1;
    d_wait_cnt_d = d_wait_cnt_q;
    if (d_wait && d_wait_cnt_q != 16'hFFFF) d_wait_cnt_d = d_wait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRI_D;
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= '0;
      i_wait_cnt_q <= '0;
      d_wait_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      i_wait_cnt_q <= i_wait_cnt_d;
      d_wait_cnt_q <= d_wait_cnt_d;
    end
  end

  // Read data is steered from the SRAM straight through; the idle port sees zero.
  always_comb begin
    i_rvalid = (resp_owner_q == OWN_IFETCH);
    d_rvalid = (resp_owner_q == OWN_DATA);
    i_rdata  = i_rvalid ? sram_rdata_i : '0;
    d_rdata  = d_rvalid ? sram_rdata_i : '0;
  end

  assign i_wait_cnt = i_wait_cnt_q;
  assign d_wait_cnt = d_wait_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand-written priority, reset and
// saturation sequences; read responses are checked against a scoreboard queue.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, STARVE_LIMIT = 4
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [12:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, i_wait, d_wait;
  logic [31:0] i_rdata, d_rdata;
  logic        sram_cs, sram_we;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_wmask;
  logic [15:0] i_wait_cnt, d_wait_cnt;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_wait(i_wait), .d_wait(d_wait),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata),
    .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
  );

  // Saturation instance, STARVE_LIMIT = 15
  logic        rst_s, i_req_s, d_req_s;
  logic        i_gnt_s, i_rvalid_s, d_gnt_s, d_rvalid_s, i_wait_s, d_wait_s;
  logic [31:0] i_rdata_s, d_rdata_s, sram_wdata_s;
  logic        sram_cs_s, sram_we_s;
  logic [12:0] sram_addr_s;
  logic [3:0]  sram_wmask_s;
  logic [15:0] i_wait_cnt_s, d_wait_cnt_s;
  logic [12:0] zero_addr = '0;
  logic [31:0] zero_data = '0;
  logic [3:0]  zero_mask = '0;
  logic        zero_bit  = 1'b0;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(32), .STARVE_LIMIT(15)) dut_sat (
    .clk(clk), .rst(rst_s),
    .i_req(i_req_s), .i_addr(zero_addr), .i_gnt(i_gnt_s), .i_rvalid(i_rvalid_s), .i_rdata(i_rdata_s),
    .d_req(d_req_s), .d_we(zero_bit), .d_addr(zero_addr), .d_wdata(zero_data), .d_wmask(zero_mask),
    .d_gnt(d_gnt_s), .d_rvalid(d_rvalid_s), .d_rdata(d_rdata_s),
    .i_wait(i_wait_s), .d_wait(d_wait_s),
    .sram_cs_o(sram_cs_s), .sram_we_o(sram_we_s), .sram_addr_o(sram_addr_s),
    .sram_wdata_o(sram_wdata_s), .sram_wmask_o(sram_wmask_s), .sram_rdata_i(zero_data),
    .i_wait_cnt(i_wait_cnt_s), .d_wait_cnt(d_wait_cnt_s)
  );

  // SRAM model: byte-masked writes, registered read
  logic [31:0] mem [0:8191];
  initial sram_rdata = '0;
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        i_req;
    logic [12:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [12:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        e_ig;
    logic        e_dg;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    int          due;
    bit          is_i;
    logic [31:0] data;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    exp_iw = 0;
  int    exp_dw = 0;
  bit    sat_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [12:0] ia, input logic dr, input logic we,
                              input logic [12:0] da, input logic [31:0] wd, input logic [3:0] wm,
                              input logic ig, input logic dg, input logic [31:0] rd);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = we; v.d_addr = da;
    v.d_wdata = wd; v.d_wmask = wm; v.e_ig = ig; v.e_dg = dg; v.e_rdata = rd;
    return v;
  endfunction

  task automatic check_resp();
    resp_t r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      if (r.is_i) begin
        chk("i_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("i_rdata", i_rdata, r.data);
        chk("d_rvalid_idle", {31'd0, d_rvalid}, 32'd0);
        chk("d_rdata_idle", d_rdata, 32'd0);
      end else begin
        chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("d_rdata", d_rdata, r.data);
        chk("i_rvalid_idle", {31'd0, i_rvalid}, 32'd0);
        chk("i_rdata_idle", i_rdata, 32'd0);
      end
    end else begin
      chk("no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge. stop_at_neg leaves time at negedge.
  task automatic run_vec(input vec_t v, input bit stop_at_neg);
    logic e_we;
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
    d_wdata = v.d_wdata; d_wmask = v.d_wmask;
    e_we = v.e_dg & v.d_we;
    @(negedge clk);
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, v.e_ig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, v.e_dg});
    chk("sram_cs", {31'd0, sram_cs}, {31'd0, v.e_ig | v.e_dg});
    chk("sram_we", {31'd0, sram_we}, {31'd0, e_we});
    chk("sram_wmask", {28'd0, sram_wmask}, v.e_dg ? {28'd0, v.d_wmask} : 32'd0);
    if (v.e_ig | v.e_dg)
      chk("sram_addr", {19'd0, sram_addr}, v.e_ig ? {19'd0, v.i_addr} : {19'd0, v.d_addr});
    if (e_we) chk("sram_wdata", sram_wdata, v.d_wdata);
    chk("i_wait", {31'd0, i_wait}, {31'd0, v.i_req & ~v.e_ig});
    chk("d_wait", {31'd0, d_wait}, {31'd0, v.d_req & ~v.e_dg});
    check_resp();
    exp_iw += int'(v.i_req & ~v.e_ig);
    exp_dw += int'(v.d_req & ~v.e_dg);
    if (!stop_at_neg) begin
      if (v.e_ig) sb.push_back('{due: cyc + 1, is_i: 1'b1, data: v.e_rdata});
      else if (v.e_dg && !v.d_we) sb.push_back('{due: cyc + 1, is_i: 1'b0, data: v.e_rdata});
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Main test
  initial begin
    rst = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h010] = 32'h0000_0013;
    mem[13'h020] = 32'h1111_1111;
    mem[13'h030] = 32'h2222_2222;
    mem[13'h200] = 32'hCAFE_F00D;

    //        ir ia      dr we da      wdata         wm       ig dg rdata
    tbl.push_back(mk(0, 13'h000, 0, 0, 13'h000, 32'h0,         4'b0000, 0, 0, 32'h0));
    tbl.push_back(mk(1, 13'h010, 0, 0, 13'h000, 32'h0,         4'b0000, 1, 0, 32'h0000_0013));
    tbl.push_back(mk(0, 13'h000, 1, 1, 13'h100, 32'hDEADBEEF,  4'b0011, 0, 1, 32'h0));
    tbl.push_back(mk(0, 13'h000, 1, 0, 13'h100, 32'h0,         4'b0000, 0, 1, 32'h0000_BEEF));
    tbl.push_back(mk(1, 13'h020, 0, 0, 13'h000, 32'h0,         4'b0000, 1, 0, 32'h1111_1111));
    tbl.push_back(mk(0, 13'h000, 1, 0, 13'h200, 32'h0,         4'b0000, 0, 1, 32'hCAFE_F00D));
    tbl.push_back(mk(1, 13'h030, 0, 0, 13'h000, 32'h0,         4'b0000, 1, 0, 32'h2222_2222));
    tbl.push_back(mk(1, 13'h010, 1, 0, 13'h020, 32'h0,         4'b0000, 0, 1, 32'h1111_1111));
    tbl.push_back(mk(1, 13'h010, 1, 0, 13'h030, 32'h0,         4'b0000, 0, 1, 32'h2222_2222));
    tbl.push_back(mk(1, 13'h010, 1, 0, 13'h200, 32'h0,         4'b0000, 0, 1, 32'hCAFE_F00D));
    tbl.push_back(mk(1, 13'h010, 1, 0, 13'h100, 32'h0,         4'b0000, 0, 1, 32'h0000_BEEF));
    tbl.push_back(mk(1, 13'h010, 1, 0, 13'h020, 32'h0,         4'b0000, 1, 0, 32'h0000_0013));
    tbl.push_back(mk(1, 13'h020, 1, 0, 13'h020, 32'h0,         4'b0000, 0, 1, 32'h1111_1111));
    tbl.push_back(mk(1, 13'h020, 1, 1, 13'h104, 32'hA5A5A5A5,  4'b1111, 0, 1, 32'h0));
    tbl.push_back(mk(1, 13'h020, 0, 0, 13'h000, 32'h0,         4'b0000, 1, 0, 32'h1111_1111));
    tbl.push_back(mk(1, 13'h030, 1, 0, 13'h104, 32'h0,         4'b0000, 0, 1, 32'hA5A5_A5A5));
    tbl.push_back(mk(1, 13'h030, 0, 0, 13'h000, 32'h0,         4'b0000, 1, 0, 32'h2222_2222));
    tbl.push_back(mk(0, 13'h000, 0, 0, 13'h000, 32'h0,         4'b0000, 0, 0, 32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_i_wait_cnt", {16'd0, i_wait_cnt}, 32'd0);
    chk("rst_d_wait_cnt", {16'd0, d_wait_cnt}, 32'd0);
    chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) run_vec(tbl[k], 1'b0);

    // Both ports saturated: D,D,D,D,I repeating
    for (int k = 0; k < 25; k++)
      run_vec(mk(1, 13'h010, 1, 0, 13'h020, 32'h0, 4'b0000,
                 (k % 5) == 4, (k % 5) != 4,
                 ((k % 5) == 4) ? 32'h0000_0013 : 32'h1111_1111), 1'b0);
    run_vec(mk(0, 13'h000, 0, 0, 13'h000, 32'h0, 4'b0000, 0, 0, 32'h0), 1'b0);
    chk("i_wait_cnt_a", {16'd0, i_wait_cnt}, exp_iw);
    chk("d_wait_cnt_a", {16'd0, d_wait_cnt}, exp_dw);

    // Reset with a load in flight and PRI_I pending
    for (int k = 0; k < 4; k++)
      run_vec(mk(1, 13'h010, 1, 0, 13'h200, 32'h0, 4'b0000, 0, 1, 32'hCAFE_F00D), k == 3);
    rst = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("rstb_d_rvalid0", {31'd0, d_rvalid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cyc++;
      chk("rstb_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("rstb_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("rel_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rel_i_rdata", i_rdata, 32'd0);
    chk("rel_d_rdata", d_rdata, 32'd0);
    chk("rel_i_wait_cnt", {16'd0, i_wait_cnt}, 32'd0);
    chk("rel_d_wait_cnt", {16'd0, d_wait_cnt}, 32'd0);
    chk("rel_sram_cs", {31'd0, sram_cs}, 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    chk("post_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    sb.delete();
    exp_iw = 0;
    exp_dw = 0;
    for (int k = 0; k < 5; k++)
      run_vec(mk(1, 13'h030, 1, 0, 13'h010, 32'h0, 4'b0000,
                 k == 4, k != 4, (k == 4) ? 32'h2222_2222 : 32'h0000_0013), 1'b0);
    run_vec(mk(0, 13'h000, 0, 0, 13'h000, 32'h0, 4'b0000, 0, 0, 32'h0), 1'b0);
    chk("i_wait_cnt_b", {16'd0, i_wait_cnt}, exp_iw);
    chk("d_wait_cnt_b", {16'd0, d_wait_cnt}, exp_dw);

    for (int i = 0; i < 100000 && !sat_done; i++) @(posedge clk);
    if (!sat_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL sat_timeout: got not done expected done");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Saturation of the wait counters with STARVE_LIMIT = 15
  initial begin
    int n;
    rst_s = 1'b0; i_req_s = 1'b0; d_req_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    i_req_s = 1'b1; d_req_s = 1'b1;
    n = 16000;
    repeat (16000) @(posedge clk);
    #1;
    chk("sat_mid_i", {16'd0, i_wait_cnt_s}, 32'(n - n / 16));
    chk("sat_mid_d", {16'd0, d_wait_cnt_s}, 32'(n / 16));
    n = 70000;
    repeat (70000 - 16000) @(posedge clk);
    #1;
    chk("sat_i_wait_cnt", {16'd0, i_wait_cnt_s}, 32'h0000_FFFF);
    chk("sat_d_wait_cnt", {16'd0, d_wait_cnt_s}, 32'(n / 16));
    n = 70040;
    repeat (40) @(posedge clk);
    #1;
    chk("sat_i_hold", {16'd0, i_wait_cnt_s}, 32'h0000_FFFF);
    chk("sat_d_hold", {16'd0, d_wait_cnt_s}, 32'(n / 16));
    sat_done = 1'b1;
  end

endmodule
